// File: rtl/uart_frame_sender.sv
// Framed UART burst sender: header, 16-bit length, FRAME_LEN FIFO payload bytes,
// optional checksum byte (compiled in with `define UART_FRAME_CHECKSUM_EN). Needs BAUD_DIV >= 2.
module uart_frame_sender #(
  parameter int          CLK_FREQ  = 200000000,
  parameter int          UART_BPS  = 115200,
  parameter int          FRAME_LEN = 405,
  parameter logic [7:0]  HDR0      = 8'hA5,
  parameter logic [7:0]  HDR1      = 8'h5A
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       capture_busy,
  input  logic       force_start,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_dout,
  output logic       uart_txd,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int             BAUD_DIV  = CLK_FREQ / UART_BPS;
  localparam int             CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0]  BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [15:0]    FLEN      = 16'(FRAME_LEN);
  localparam logic [15:0]    PAY_LAST  = 16'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_LENH,
    S_LENL,
    S_PAY,
`ifdef UART_FRAME_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [3:0]      bit_q, bit_d;     // 0 start, 1..8 data, 9 stop
  logic [7:0]      byte_q, byte_d;
  logic [7:0]      nxt_q, nxt_d;     // prefetched payload byte
  logic [15:0]     pay_q, pay_d;
  logic            under_q, under_d;
  logic            pend_q, pend_d;   // fifo_dout valid this cycle
  logic            txd_q, txd_d;
  logic            cap_q, cap_d;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]      csum_q, csum_d;
`endif

  logic       trig, bit_wrap, byte_end, fetch_slot;
  logic [7:0] pay_byte;
  logic [2:0] didx;

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    nxt_d      = nxt_q;
    pay_d      = pay_q;
    under_d    = under_q;
    pend_d     = 1'b0;
    cap_d      = capture_busy;
`ifdef UART_FRAME_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    trig       = (cap_q & ~capture_busy) | force_start;
    bit_wrap   = (baud_q == BAUD_LAST);
    byte_end   = bit_wrap && (bit_q == 4'd9);
    pay_byte   = pend_q ? fifo_dout : nxt_q;
    fetch_slot = ((state_q == S_LENL) || (state_q == S_PAY && pay_q != PAY_LAST)) &&
                 (bit_q == 4'd9) && (baud_q == '0);
    fifo_rd_en = fetch_slot & ~fifo_empty;

    // Missing payload bytes are replaced by 0x00 and flagged.
    if (fetch_slot) begin
      pend_d = ~fifo_empty;
      if (fifo_empty) begin
        nxt_d   = 8'h00;
        under_d = 1'b1;
      end
    end
    if (pend_q) nxt_d = fifo_dout;

    case (state_q)
      S_IDLE: begin
        if (trig) begin
          state_d = S_HDR0;
          byte_d  = HDR0;
          baud_d  = '0;
          bit_d   = 4'd0;
          under_d = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        baud_d = bit_wrap ? '0 : baud_q + 1'b1;
        if (bit_wrap) bit_d = bit_q + 4'd1;
        if (byte_end) begin
          bit_d = 4'd0;
          case (state_q)
            S_HDR0: begin state_d = S_HDR1; byte_d = HDR1; end
            S_HDR1: begin state_d = S_LENH; byte_d = FLEN[15:8]; end
            S_LENH: begin state_d = S_LENL; byte_d = FLEN[7:0]; end
            S_LENL: begin state_d = S_PAY;  byte_d = pay_byte; pay_d = 16'd0; end
            S_PAY: begin
              if (pay_q == PAY_LAST) begin
`ifdef UART_FRAME_CHECKSUM_EN
                state_d = S_CSUM;
                byte_d  = csum_q;
`else
                state_d = S_DONE;
`endif
              end else begin
                byte_d = pay_byte;
                pay_d  = pay_q + 16'd1;
              end
            end
            default: state_d = S_DONE;
          endcase
        end
      end
    endcase

`ifdef UART_FRAME_CHECKSUM_EN
    // Sum each byte as it is loaded, so the CSUM byte is ready at the last payload wrap.
    if (byte_end && (state_d == S_LENH || state_d == S_LENL || state_d == S_PAY))
      csum_d = csum_q + byte_d;
`endif

    didx = bit_d[2:0] - 3'd1;
    if (state_d == S_IDLE || state_d == S_DONE) txd_d = 1'b1;
    else if (bit_d == 4'd0)                      txd_d = 1'b0;
    else if (bit_d == 4'd9)                      txd_d = 1'b1;
    else                                         txd_d = byte_d[didx];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 4'd0;
      byte_q  <= 8'h00;
      nxt_q   <= 8'h00;
      pay_q   <= 16'd0;
      under_q <= 1'b0;
      pend_q  <= 1'b0;
      txd_q   <= 1'b1;
      cap_q   <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      nxt_q   <= nxt_d;
      pay_q   <= pay_d;
      under_q <= under_d;
      pend_q  <= pend_d;
      txd_q   <= txd_d;
      cap_q   <= cap_d;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign uart_txd   = txd_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
  assign frame_done = (state_q == S_DONE);
  assign underrun   = under_q;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Bench for uart_frame_sender: directed table, random frames against a byte-level model,
// reset abort, bit timing on the first header byte and a FRAME_LEN=405 instance.
module tb_uart_frame_sender;

  localparam int FL = 4;
  localparam int BD = 10;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam int C = 1;
`else
  localparam int C = 0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       capture_busy = 1'b0, force_start = 1'b0, fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en, uart_txd, busy, frame_done, underrun;

  logic       cap_b = 1'b0, force_b = 1'b0, empty_b = 1'b0;
  logic [7:0] dout_b = 8'h11;
  logic       rd_b_en, txd_b, busy_b, done_b, under_b;

  uart_frame_sender #(.CLK_FREQ(1000000), .UART_BPS(100000), .FRAME_LEN(FL)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .capture_busy(capture_busy),
    .force_start(force_start), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .uart_txd(uart_txd), .busy(busy), .frame_done(frame_done),
    .underrun(underrun));

  uart_frame_sender #(.CLK_FREQ(300000), .UART_BPS(100000), .FRAME_LEN(405)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .capture_busy(cap_b),
    .force_start(force_b), .fifo_empty(empty_b), .fifo_rd_en(rd_b_en),
    .fifo_dout(dout_b), .uart_txd(txd_b), .busy(busy_b), .frame_done(done_b),
    .underrun(under_b));

  always #5 sys_clk = ~sys_clk;

  int errs = 0, checks = 0;
  int cyc = 0;
  int done_cnt = 0, done_cyc = 0, rd_cnt = 0;
  int done_b_cnt = 0, done_b_cyc = 0, rd_b_cnt = 0;
  int stop_err = 0, stop_err_b = 0;
  bit last_und = 1'b0;
  logic [7:0] fq[$];
  logic [7:0] rxq[$], rxbq[$];
  int         rxt[$], rxbt[$];

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Capture FIFO: data appears the cycle after the strobe.
  always @(posedge sys_clk) if (fifo_rd_en && fq.size() != 0) fifo_dout <= fq.pop_front();
  always @(negedge sys_clk) fifo_empty = (fq.size() == 0);

  always @(negedge sys_clk) begin
    if (frame_done) begin done_cnt++; done_cyc = cyc; end
    if (fifo_rd_en) rd_cnt++;
    if (done_b) begin done_b_cnt++; done_b_cyc = cyc; end
    if (rd_b_en) rd_b_cnt++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Called right after the negedge where a start bit was first seen; returns at the last
  // cycle of the stop bit so back-to-back bytes are picked up.
  task automatic rx_byte(input bit big, output logic [7:0] b, output bit stop_ok);
    int div;
    div = big ? 3 : BD;
    repeat (div / 2) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      repeat (div) @(negedge sys_clk);
      b[i] = big ? txd_b : uart_txd;
    end
    repeat (div) @(negedge sys_clk);
    stop_ok = big ? (txd_b == 1'b1) : (uart_txd == 1'b1);
    repeat (div - div / 2 - 1) @(negedge sys_clk);
  endtask

  initial begin
    logic [7:0] b; bit ok; int t;
    forever begin
      @(negedge sys_clk);
      if (uart_txd === 1'b0) begin
        t = cyc;
        rx_byte(1'b0, b, ok);
        rxq.push_back(b); rxt.push_back(t);
        if (!ok) stop_err++;
      end
    end
  end

  initial begin
    logic [7:0] b; bit ok; int t;
    forever begin
      @(negedge sys_clk);
      if (txd_b === 1'b0) begin
        t = cyc;
        rx_byte(1'b1, b, ok);
        rxbq.push_back(b); rxbt.push_back(t);
        if (!ok) stop_err_b++;
      end
    end
  end

  // Reference: what the spec says a frame must contain, given the FIFO contents.
  function automatic void model(input logic [7:0] d[$], output logic [7:0] e[$],
                                output int rd, output bit und);
    int s;
    logic [7:0] b;
    e = {};
    e.push_back(8'hA5); e.push_back(8'h5A);
    e.push_back(8'(FL / 256)); e.push_back(8'(FL % 256));
    s = FL / 256 + FL % 256;
    for (int i = 0; i < FL; i++) begin
      b = (i < d.size()) ? d[i] : 8'h00;
      e.push_back(b);
      s += int'(b);
    end
    if (C == 1) e.push_back(8'(s));
    rd  = (d.size() < FL) ? d.size() : FL;
    und = (d.size() < FL);
  endfunction

  task automatic run_frame(input string nm, input logic [7:0] d[$], input int trig,
                           input bit mid, input logic [7:0] e[$], input int exp_rd,
                           input bit exp_und);
    int  rxb, db, rb, first, got, left;
    bit  seen;
    fq.delete();
    foreach (d[i]) fq.push_back(d[i]);
    repeat (2) @(negedge sys_clk);
    chk({nm, "_und_sticky"}, int'(underrun), int'(last_und));
    rxb = rxq.size(); db = done_cnt; rb = rd_cnt;
    if (trig != 1) begin capture_busy = 1'b1; @(negedge sys_clk); capture_busy = 1'b0; end
    if (trig != 0) force_start = 1'b1;
    @(negedge sys_clk);
    force_start = 1'b0;
    chk({nm, "_start_busy_txd"}, int'({busy, uart_txd}), 2);
    chk({nm, "_und_cleared"}, int'(underrun), 0);
    if (mid) begin
      repeat (450) @(negedge sys_clk);
      capture_busy = 1'b1; @(negedge sys_clk); capture_busy = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge sys_clk);
      if (done_cnt != db) seen = 1'b1;
    end
    if (!seen) chk({nm, "_done_timeout"}, 0, 1);
    repeat (150) @(negedge sys_clk);
    chk({nm, "_done_count"}, done_cnt - db, 1);
    chk({nm, "_byte_count"}, rxq.size() - rxb, e.size());
    foreach (e[i]) begin
      got = (rxb + i < rxq.size()) ? int'(rxq[rxb + i]) : -1;
      chk($sformatf("%s_byte%0d", nm, i), got, int'(e[i]));
    end
    first = (rxq.size() > rxb) ? rxt[rxb] : -100000;
    chk({nm, "_duration"}, done_cyc - first, e.size() * 10 * BD);
    chk({nm, "_rd_pulses"}, rd_cnt - rb, exp_rd);
    left = (d.size() > exp_rd) ? d.size() - exp_rd : 0;
    chk({nm, "_fifo_left"}, fq.size(), left);
    chk({nm, "_underrun"}, int'(underrun), int'(exp_und));
    chk({nm, "_idle_after"}, int'(busy), 0);
    last_und = exp_und;
    fq.delete();
  endtask

  typedef struct {
    int         n;
    logic [7:0] d [6];
    int         trig;    // 0 edge, 1 force, 2 both together
    bit         mid;     // extra capture_busy edge during payload
    logic [7:0] pay [4];
    logic [7:0] csum;
    int         rd;
    bit         und;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [7:0] d[$], e[$];
    logic [7:0] h;
    int  rd, nbad, db, t0;
    bit  und, seen;

    tbl[0] = '{4, '{8'h01,8'h02,8'h03,8'h04,8'h00,8'h00}, 0, 1'b0,
               '{8'h01,8'h02,8'h03,8'h04}, 8'h0E, 4, 1'b0};
    tbl[1] = '{2, '{8'h10,8'h20,8'h00,8'h00,8'h00,8'h00}, 1, 1'b0,
               '{8'h10,8'h20,8'h00,8'h00}, 8'h34, 2, 1'b1};
    tbl[2] = '{4, '{8'h11,8'h22,8'h33,8'h44,8'h00,8'h00}, 2, 1'b0,
               '{8'h11,8'h22,8'h33,8'h44}, 8'hAE, 4, 1'b0};
    tbl[3] = '{4, '{8'h05,8'h06,8'h07,8'h08,8'h00,8'h00}, 0, 1'b1,
               '{8'h05,8'h06,8'h07,8'h08}, 8'h1E, 4, 1'b0};
    tbl[4] = '{6, '{8'hFF,8'h80,8'h7F,8'h01,8'hAA,8'hBB}, 1, 1'b0,
               '{8'hFF,8'h80,8'h7F,8'h01}, 8'h03, 4, 1'b0};
    tbl[5] = '{0, '{8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 0, 1'b0,
               '{8'h00,8'h00,8'h00,8'h00}, 8'h04, 0, 1'b1};

    repeat (3) @(negedge sys_clk);
    chk("rst_txd", int'(uart_txd), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_rd_en", int'(fifo_rd_en), 0);
    chk("rst_underrun", int'(underrun), 0);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    // Bit timing of HDR0 (FIFO empty; the frame then runs to completion).
    h = 8'hA5;
    force_start = 1'b1; @(negedge sys_clk); force_start = 1'b0;
    db = done_cnt; nbad = 0;
    for (int k = 0; k < 100; k++) begin
      int bi; logic ex;
      bi = k / 10;
      ex = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : h[bi - 1];
      if (uart_txd !== ex) nbad++;
      @(negedge sys_clk);
    end
    chk("hdr0_bit_timing_errors", nbad, 0);
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge sys_clk);
      if (done_cnt != db) seen = 1'b1;
    end
    chk("hdr0_frame_done_seen", int'(seen), 1);
    last_und = 1'b1;
    repeat (20) @(negedge sys_clk);

    foreach (tbl[v]) begin
      d = {}; e = {8'hA5, 8'h5A, 8'h00, 8'h04};
      for (int i = 0; i < tbl[v].n; i++) d.push_back(tbl[v].d[i]);
      for (int i = 0; i < 4; i++) e.push_back(tbl[v].pay[i]);
      if (C == 1) e.push_back(tbl[v].csum);
      run_frame($sformatf("tbl%0d", v), d, tbl[v].trig, tbl[v].mid, e, tbl[v].rd, tbl[v].und);
    end

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, 6);
      d = {};
      for (int i = 0; i < n; i++) d.push_back(8'($urandom));
      model(d, e, rd, und);
      run_frame($sformatf("rnd%0d", r), d, $urandom_range(0, 2), 1'b0, e, rd, und);
    end

    // Reset during the second payload byte.
    fq.delete();
    for (int i = 1; i <= 4; i++) fq.push_back(8'(i));
    repeat (2) @(negedge sys_clk);
    db = done_cnt;
    force_start = 1'b1; @(negedge sys_clk); force_start = 1'b0;
    repeat (550) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_txd", int'(uart_txd), 1);
    chk("midrst_busy", int'(busy), 0);
    repeat (3) @(negedge sys_clk);
    chk("midrst_rd_en", int'(fifo_rd_en), 0);
    sys_rst_n = 1'b1;
    repeat (200) @(negedge sys_clk);
    chk("midrst_no_done", done_cnt - db, 0);
    chk("midrst_idle", int'(busy), 0);
    last_und = 1'b0;
    d = {8'h01, 8'h02, 8'h03, 8'h04};
    model(d, e, rd, und);
    run_frame("after_rst", d, 1, 1'b0, e, rd, und);

    // FRAME_LEN=405 instance with an always-full FIFO returning 0x11.
    db = done_b_cnt; rd = rd_b_cnt; t0 = rxbq.size();
    force_b = 1'b1; @(negedge sys_clk); force_b = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      @(negedge sys_clk);
      if (done_b_cnt != db) seen = 1'b1;
    end
    chk("big_done_seen", int'(seen), 1);
    repeat (20) @(negedge sys_clk);
    chk("big_rd_pulses", rd_b_cnt - rd, 405);
    chk("big_byte_count", rxbq.size() - t0, 409 + C);
    if (rxbq.size() >= t0 + 5) begin
      chk("big_lenh", int'(rxbq[t0 + 2]), 8'h01);
      chk("big_lenl", int'(rxbq[t0 + 3]), 8'h95);
      chk("big_pay0", int'(rxbq[t0 + 4]), 8'h11);
      chk("big_duration", done_b_cyc - rxbt[t0], (409 + C) * 30);
      if (C == 1 && rxbq.size() >= t0 + 410)
        chk("big_csum", int'(rxbq[t0 + 409]), (1 + 8'h95 + 405 * 8'h11) % 256);
    end else chk("big_rx_short", rxbq.size() - t0, 409 + C);
    chk("big_underrun", int'(under_b), 0);
    chk("big_idle", int'(busy_b), 0);
    chk("stop_bits_a", stop_err, 0);
    chk("stop_bits_b", stop_err_b, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
